frame_rx_fsm: RTL

//  Receive-side framer, the counterpart of the frame transmitter FSM. Parses the word stream
//  SOP, PRE_LEN x PREAMBLE, SOF, payload, CRC word, EOP. Control words are flagged by RX_K.

---
 rtl/frame_rx_fsm_if.sv | 29 ++
 rtl/frame_rx_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/frame_rx_fsm_if.sv
// Bundle between the receive framer, the link word decoder, the CRC engine and the payload FIFO.
// slave = framer side, master = environment side.
interface frame_rx_fsm_if #(
   parameter int DW = 16
);
   logic          RX_VLD;
   logic          RX_K;
   logic [DW-1:0] RX_DATA;
   logic [DW-1:0] CRC_IN;
   logic          CRC_CLR;
   logic          CRC_EN;
   logic [DW-1:0] DATA_OUT;
   logic          DATA_VLD;
   logic          FRM_START;
   logic          FRM_END;
   logic          CRC_OK;
   logic          FRM_ERR;
   logic [2:0]    FRM_STATE;

   modport slave (
      input  RX_VLD, RX_K, RX_DATA, CRC_IN,
      output CRC_CLR, CRC_EN, DATA_OUT, DATA_VLD, FRM_START, FRM_END, CRC_OK, FRM_ERR, FRM_STATE
   );

   modport master (
      output RX_VLD, RX_K, RX_DATA, CRC_IN,
      input  CRC_CLR, CRC_EN, DATA_OUT, DATA_VLD, FRM_START, FRM_END, CRC_OK, FRM_ERR, FRM_STATE
   );
endinterface

// File: rtl/frame_rx_fsm.sv
// Receive-side framer: parses SOP / preamble / SOF / payload / CRC / EOP and checks the trailing CRC.
// Define FRM_RX_STATS_EN to add saturating FRM_CNT, CRC_ERR_CNT and FRM_ERR_CNT counters.
module frame_rx_fsm #(
   parameter int            DW      = 16,
   parameter logic [DW-1:0] SOP_W   = 16'h01BC,
   parameter logic [DW-1:0] PRE_W   = 16'h55BC,
   parameter logic [DW-1:0] SOF_W   = 16'hD5BC,
   parameter logic [DW-1:0] EOP_W   = 16'hFDBC,
   parameter int            PRE_LEN = 3,
   parameter int            MAX_LEN = 1024
) (
   input  logic          CLK,
   input  logic          RST_N,
`ifdef FRM_RX_STATS_EN
   output logic [15:0]   FRM_CNT,
   output logic [15:0]   CRC_ERR_CNT,
   output logic [15:0]   FRM_ERR_CNT,
`endif
   frame_rx_fsm_if.slave bus
);

   localparam int LW = $clog2(MAX_LEN + 2);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      PRE   = 3'b001,
      SOFW  = 3'b010,
      DATA  = 3'b011,
      CHECK = 3'b100,
      ERR   = 3'b101
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    pcnt_q, pcnt_d;
   logic [LW-1:0] len_q, len_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          have_q, have_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dvld_q, dvld_d;
   logic          clr_q, clr_d;
   logic          start_q, start_d;
   logic          end_q, end_d;
   logic          ok_q, ok_d;
   logic          err_q, err_d;

   always_ff @(posedge CLK) begin
      // NOTE: every register uses <= so all of them sample the same pre-edge values.
      if (!RST_N) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         len_q   <= '0;
         hold_q  <= '0;
         have_q  <= 1'b0;
         dout_q  <= '0;
         dvld_q  <= 1'b0;
         clr_q   <= 1'b0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         have_q  <= have_d;
         dout_q  <= dout_d;
         dvld_q  <= dvld_d;
         clr_q   <= clr_d;
         start_q <= start_d;
         end_q   <= end_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: defaults first; any path that skips an assignment would otherwise infer a latch.
      state_d = state_q;
      pcnt_d  = pcnt_q;
      len_d   = len_q;
      hold_d  = hold_q;
      have_d  = have_q;
      dout_d  = dout_q;
      dvld_d  = 1'b0;
      clr_d   = 1'b0;
      start_d = 1'b0;
      end_d   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.RX_VLD && bus.RX_K && bus.RX_DATA == SOP_W) begin
            state_d = PRE;
            pcnt_d  = '0;
         end
         PRE: if (bus.RX_VLD) begin
            if (bus.RX_K && bus.RX_DATA == PRE_W) begin
               if (pcnt_q == 3'(PRE_LEN - 1)) state_d = SOFW;
               else                           pcnt_d  = pcnt_q + 3'd1;
            end else begin
               state_d = ERR;
            end
         end
         SOFW: if (bus.RX_VLD) begin
            if (bus.RX_K && bus.RX_DATA == SOF_W) begin
               state_d = DATA;
               clr_d   = 1'b1;
               start_d = 1'b1;
               len_d   = '0;
               have_d  = 1'b0;
            end else begin
               state_d = ERR;
            end
         end
         DATA: if (bus.RX_VLD) begin
            if (!bus.RX_K) begin
               // One-word delay line: the last word before EOP is the CRC and never leaves.
               if (have_q) begin
                  dout_d = hold_q;
                  dvld_d = 1'b1;
               end
               hold_d = bus.RX_DATA;
               have_d = 1'b1;
               len_d  = len_q + LW'(1);
               if (len_d == LW'(MAX_LEN + 1)) state_d = ERR;
            end else if (bus.RX_DATA == EOP_W) begin
               state_d = have_q ? CHECK : ERR;
            end else if (bus.RX_DATA == SOP_W) begin
               err_d   = 1'b1;
               state_d = PRE;
               pcnt_d  = '0;
            end else begin
               state_d = ERR;
            end
         end
         CHECK: begin
            end_d   = 1'b1;
            ok_d    = (hold_q == bus.CRC_IN);
            state_d = IDLE;
         end
         ERR: begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.CRC_CLR   = clr_q;
   assign bus.CRC_EN    = dvld_q;
   assign bus.DATA_OUT  = dout_q;
   assign bus.DATA_VLD  = dvld_q;
   assign bus.FRM_START = start_q;
   assign bus.FRM_END   = end_q;
   assign bus.CRC_OK    = ok_q;
   assign bus.FRM_ERR   = err_q;
   assign bus.FRM_STATE = state_q;

`ifdef FRM_RX_STATS_EN
   logic [15:0] frm_cnt_q, crc_err_cnt_q, frm_err_cnt_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         frm_cnt_q     <= '0;
         crc_err_cnt_q <= '0;
         frm_err_cnt_q <= '0;
      end else begin
         if (end_q && ok_q && frm_cnt_q != 16'hFFFF)      frm_cnt_q     <= frm_cnt_q + 16'd1;
         if (end_q && !ok_q && crc_err_cnt_q != 16'hFFFF) crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
         if (err_q && frm_err_cnt_q != 16'hFFFF)          frm_err_cnt_q <= frm_err_cnt_q + 16'd1;
      end
   end

   assign FRM_CNT     = frm_cnt_q;
   assign CRC_ERR_CNT = crc_err_cnt_q;
   assign FRM_ERR_CNT = frm_err_cnt_q;
`endif

endmodule
